sc_gravity_scheduler: RTL and testbench

- Sequences the point/piece datapath: converts debounced buttons and a gravity timer into one-cycle active-low clear/load strobes and the shift selection.
- Arbitrates between the user requesters and the automatic gravity requester, so the datapath sees at most one command per cycle.
- Tracks landings, level (gravity speed) and lives, and sits between the button debouncers and the point register/shifter datapath.

---
 rtl/sc_gravity_scheduler.sv | 271 +++++++++++++++++++++++++++
 tb/tb_sc_gravity_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_gravity_scheduler.sv
// sc_gravity_scheduler
//
// Purpose:
//   Control unit of the point/piece datapath. It turns debounced buttons and
//   an internal gravity timer into one-cycle, active-low clear/load strobes
//   and a shift selection. Only one command reaches the datapath per cycle.
//   It also keeps track of landings, the level (which sets gravity speed)
//   and the remaining lives.
//
// Ports:
//   SC_GRAVITY_SCHEDULER_CLOCK_50                  system clock, rising edge
//   SC_GRAVITY_SCHEDULER_RESET_InLow               synchronous reset, low = reset
//   SC_GRAVITY_SCHEDULER_*Button_InLow             debounced buttons, low = pressed
//   SC_GRAVITY_SCHEDULER_bottomsidecomparator_InLow low = piece on bottom row
//   SC_GRAVITY_SCHEDULER_topsidecomparator_InLow   low = landed piece overflows top
//   SC_GRAVITY_SCHEDULER_clear_OutLow              datapath clear strobe
//   SC_GRAVITY_SCHEDULER_load0_OutLow              up-load strobe
//   SC_GRAVITY_SCHEDULER_load1_OutLow              down-load strobe
//   SC_GRAVITY_SCHEDULER_shiftselection_Out        11 hold, 01 left, 10 right
//   SC_GRAVITY_SCHEDULER_level_Out                 current level
//   SC_GRAVITY_SCHEDULER_lives_Out                 remaining lives
//   SC_GRAVITY_SCHEDULER_landed_OutHigh            one-cycle pulse per landing
//   SC_GRAVITY_SCHEDULER_gameover_OutHigh          high while the game is over
module sc_gravity_scheduler #(
   parameter int TICK_WIDTH         = 26,
   parameter int BASE_PERIOD        = 25000000,
   parameter int PERIOD_STEP        = 2500000,
   parameter int MAX_LEVEL          = 7,
   parameter int LANDINGS_PER_LEVEL = 4,
   parameter int LIVES_INIT         = 3
) (
   input  logic       SC_GRAVITY_SCHEDULER_CLOCK_50,
   input  logic       SC_GRAVITY_SCHEDULER_RESET_InLow,
   input  logic       SC_GRAVITY_SCHEDULER_startButton_InLow,
   input  logic       SC_GRAVITY_SCHEDULER_upButton_InLow,
   input  logic       SC_GRAVITY_SCHEDULER_downButton_InLow,
   input  logic       SC_GRAVITY_SCHEDULER_leftButton_InLow,
   input  logic       SC_GRAVITY_SCHEDULER_rightButton_InLow,
   input  logic       SC_GRAVITY_SCHEDULER_bottomsidecomparator_InLow,
   input  logic       SC_GRAVITY_SCHEDULER_topsidecomparator_InLow,
   output logic       SC_GRAVITY_SCHEDULER_clear_OutLow,
   output logic       SC_GRAVITY_SCHEDULER_load0_OutLow,
   output logic       SC_GRAVITY_SCHEDULER_load1_OutLow,
   output logic [1:0] SC_GRAVITY_SCHEDULER_shiftselection_Out,
   output logic [2:0] SC_GRAVITY_SCHEDULER_level_Out,
   output logic [1:0] SC_GRAVITY_SCHEDULER_lives_Out,
   output logic       SC_GRAVITY_SCHEDULER_landed_OutHigh,
   output logic       SC_GRAVITY_SCHEDULER_gameover_OutHigh
);

   localparam int LAND_W = (LANDINGS_PER_LEVEL > 1) ? $clog2(LANDINGS_PER_LEVEL) : 1;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      ISSUE,
      WAIT_RELEASE,
      LAND,
      GAMEOVER
   } stateType;

   typedef enum logic [1:0] {
      CMD_UP,
      CMD_DOWN,
      CMD_LEFT,
      CMD_RIGHT
   } cmdType;

   logic clock;
   logic resetLow;
   assign clock    = SC_GRAVITY_SCHEDULER_CLOCK_50;
   assign resetLow = SC_GRAVITY_SCHEDULER_RESET_InLow;

   stateType state, nextState;
   cmdType   cmd, nextCmd;
   logic     cmdGravity, nextGravity;

   logic startReg, upReg, downReg, leftReg, rightReg;
   logic [TICK_WIDTH-1:0] counter;
   logic [TICK_WIDTH-1:0] periodLast;
   logic gravReqReg;
   logic pending;
   logic gravity;
   logic counting;
   logic allReleased;
   logic [2:0] level;
   logic [LAND_W-1:0] landings;
   logic [1:0] lives;
   logic bottomOk;
   logic topOverflow;

   assign bottomOk    = SC_GRAVITY_SCHEDULER_bottomsidecomparator_InLow;
   assign topOverflow = ~SC_GRAVITY_SCHEDULER_topsidecomparator_InLow;

   // The last counter value of one gravity period shrinks by one step per level.
   assign periodLast  = TICK_WIDTH'(BASE_PERIOD - 1 - PERIOD_STEP * int'(level));
   assign counting    = (state == RUN) || (state == ISSUE) || (state == WAIT_RELEASE);
   assign gravity     = gravReqReg | pending;
   assign allReleased = startReg & upReg & downReg & leftReg & rightReg;

   // State and command registers; a reset at any edge drops back to IDLE,
   // which also kills a strobe that is currently being driven.
   always_ff @(posedge clock) begin
      if (!resetLow) begin
         state      <= IDLE;
         cmd        <= CMD_UP;
         cmdGravity <= 1'b0;
      end else begin
         state      <= nextState;
         cmd        <= nextCmd;
         cmdGravity <= nextGravity;
      end
   end

   // Next-state logic. In RUN the gravity request (fresh or pending) wins over
   // every button; user commands then wait for all buttons to be released so
   // each press yields exactly one command.
   always_comb begin
      nextState   = state;
      nextCmd     = cmd;
      nextGravity = cmdGravity;
      case (state)
         IDLE: begin
            if (!startReg) nextState = CLEAR;
         end
         CLEAR: begin
            nextState = RUN;
         end
         RUN: begin
            if (gravity) begin
               if (bottomOk) begin
                  nextState   = ISSUE;
                  nextCmd     = CMD_DOWN;
                  nextGravity = 1'b1;
               end else begin
                  nextState = LAND;
               end
            end else if (!upReg) begin
               nextState   = ISSUE;
               nextCmd     = CMD_UP;
               nextGravity = 1'b0;
            end else if (!downReg) begin
               if (bottomOk) begin
                  nextState   = ISSUE;
                  nextCmd     = CMD_DOWN;
                  nextGravity = 1'b0;
               end
            end else if (!leftReg) begin
               nextState   = ISSUE;
               nextCmd     = CMD_LEFT;
               nextGravity = 1'b0;
            end else if (!rightReg) begin
               nextState   = ISSUE;
               nextCmd     = CMD_RIGHT;
               nextGravity = 1'b0;
            end
         end
         ISSUE: begin
            nextState = cmdGravity ? RUN : WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (allReleased) nextState = RUN;
         end
         LAND: begin
            if (topOverflow && (lives <= 2'd1)) nextState = GAMEOVER;
            else                                nextState = CLEAR;
         end
         GAMEOVER: begin
            if (!startReg) nextState = CLEAR;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Moore output decode from the state and the registered command. Unknown
   // encodings fall into the default and produce idle outputs.
   always_comb begin
      SC_GRAVITY_SCHEDULER_clear_OutLow       = 1'b1;
      SC_GRAVITY_SCHEDULER_load0_OutLow       = 1'b1;
      SC_GRAVITY_SCHEDULER_load1_OutLow       = 1'b1;
      SC_GRAVITY_SCHEDULER_shiftselection_Out = 2'b11;
      SC_GRAVITY_SCHEDULER_landed_OutHigh     = 1'b0;
      SC_GRAVITY_SCHEDULER_gameover_OutHigh   = 1'b0;
      case (state)
         CLEAR:    SC_GRAVITY_SCHEDULER_clear_OutLow = 1'b0;
         ISSUE: begin
            case (cmd)
               CMD_UP:    SC_GRAVITY_SCHEDULER_load0_OutLow       = 1'b0;
               CMD_DOWN:  SC_GRAVITY_SCHEDULER_load1_OutLow       = 1'b0;
               CMD_LEFT:  SC_GRAVITY_SCHEDULER_shiftselection_Out = 2'b01;
               default:   SC_GRAVITY_SCHEDULER_shiftselection_Out = 2'b10;
            endcase
         end
         LAND:     SC_GRAVITY_SCHEDULER_landed_OutHigh   = 1'b1;
         GAMEOVER: SC_GRAVITY_SCHEDULER_gameover_OutHigh = 1'b1;
         default: begin
         end
      endcase
   end

   // Button sampling, gravity timer, pending request and game bookkeeping.
   // Buttons and the expiry are registered, so a press or an expiry seen in
   // RUN becomes a strobe two edges later. An expiry that occurs while the
   // FSM is not in RUN is remembered once in 'pending'.
   always_ff @(posedge clock) begin
      if (!resetLow) begin
         startReg   <= 1'b1;
         upReg      <= 1'b1;
         downReg    <= 1'b1;
         leftReg    <= 1'b1;
         rightReg   <= 1'b1;
         counter    <= '0;
         gravReqReg <= 1'b0;
         pending    <= 1'b0;
         level      <= '0;
         landings   <= '0;
         lives      <= 2'(LIVES_INIT);
      end else begin
         startReg <= SC_GRAVITY_SCHEDULER_startButton_InLow;
         upReg    <= SC_GRAVITY_SCHEDULER_upButton_InLow;
         downReg  <= SC_GRAVITY_SCHEDULER_downButton_InLow;
         leftReg  <= SC_GRAVITY_SCHEDULER_leftButton_InLow;
         rightReg <= SC_GRAVITY_SCHEDULER_rightButton_InLow;

         if (state == CLEAR) begin
            counter    <= '0;
            gravReqReg <= 1'b0;
         end else if (counting) begin
            if (counter >= periodLast) begin
               counter    <= '0;
               gravReqReg <= 1'b1;
            end else begin
               counter    <= counter + TICK_WIDTH'(1);
               gravReqReg <= 1'b0;
            end
         end else begin
            gravReqReg <= 1'b0;
         end

         if (state == CLEAR) begin
            pending <= 1'b0;
         end else if (state == RUN) begin
            if (gravity) pending <= 1'b0;
         end else if (gravReqReg) begin
            pending <= 1'b1;
         end

         if (state == LAND) begin
            if (topOverflow) begin
               if (lives != 2'd0) lives <= lives - 2'd1;
            end else if (landings == LAND_W'(LANDINGS_PER_LEVEL - 1)) begin
               landings <= '0;
               if (level != 3'(MAX_LEVEL)) level <= level + 3'd1;
            end else begin
               landings <= landings + LAND_W'(1);
            end
         end else if ((state == GAMEOVER) && !startReg) begin
            lives    <= 2'(LIVES_INIT);
            level    <= '0;
            landings <= '0;
         end
      end
   end

   assign SC_GRAVITY_SCHEDULER_level_Out = level;
   assign SC_GRAVITY_SCHEDULER_lives_Out = lives;

endmodule

// File: tb/tb_sc_gravity_scheduler.sv
// tb_sc_gravity_scheduler
//
// Purpose:
//   Self-checking bench for sc_gravity_scheduler with a short gravity period.
//   Expected values come from game rules in plain arithmetic: gravity pulses
//   every P = BASE - level*STEP clocks, one strobe per press, level from the
//   landing count, lives decremented on overflow.
//
// Ports: none (top-level bench).
module tb_sc_gravity_scheduler;

   localparam int BASE  = 16;
   localparam int STEP  = 4;
   localparam int MAXL  = 3;
   localparam int LPL   = 2;
   localparam int LIVES = 2;

   logic clock = 1'b0;
   logic resetLow;
   logic startBtn, upBtn, downBtn, leftBtn, rightBtn;
   logic bottomIn, topIn;
   logic clearOut, load0Out, load1Out, landedOut, gameoverOut;
   logic [1:0] shiftOut, livesOut;
   logic [2:0] levelOut;

   int total = 0;
   int bad   = 0;

   int cyc = 0;
   int nClear = 0, nLoad0 = 0, nLoad1 = 0, nLeft = 0, nRight = 0, nLanded = 0;
   int lastClear = 0, lastLoad1 = 0, prevLoad1 = 0, lastRight = 0;

   int kind, which, hold, gap, u0, l0, r0, obs, expv, base, t, markL;
   int c0, ld0, s0, landTotal, modelLevel;

   always #5 clock = ~clock;

   sc_gravity_scheduler #(
      .TICK_WIDTH(26),
      .BASE_PERIOD(BASE),
      .PERIOD_STEP(STEP),
      .MAX_LEVEL(MAXL),
      .LANDINGS_PER_LEVEL(LPL),
      .LIVES_INIT(LIVES)
   ) dut (
      .SC_GRAVITY_SCHEDULER_CLOCK_50(clock),
      .SC_GRAVITY_SCHEDULER_RESET_InLow(resetLow),
      .SC_GRAVITY_SCHEDULER_startButton_InLow(startBtn),
      .SC_GRAVITY_SCHEDULER_upButton_InLow(upBtn),
      .SC_GRAVITY_SCHEDULER_downButton_InLow(downBtn),
      .SC_GRAVITY_SCHEDULER_leftButton_InLow(leftBtn),
      .SC_GRAVITY_SCHEDULER_rightButton_InLow(rightBtn),
      .SC_GRAVITY_SCHEDULER_bottomsidecomparator_InLow(bottomIn),
      .SC_GRAVITY_SCHEDULER_topsidecomparator_InLow(topIn),
      .SC_GRAVITY_SCHEDULER_clear_OutLow(clearOut),
      .SC_GRAVITY_SCHEDULER_load0_OutLow(load0Out),
      .SC_GRAVITY_SCHEDULER_load1_OutLow(load1Out),
      .SC_GRAVITY_SCHEDULER_shiftselection_Out(shiftOut),
      .SC_GRAVITY_SCHEDULER_level_Out(levelOut),
      .SC_GRAVITY_SCHEDULER_lives_Out(livesOut),
      .SC_GRAVITY_SCHEDULER_landed_OutHigh(landedOut),
      .SC_GRAVITY_SCHEDULER_gameover_OutHigh(gameoverOut)
   );

   // Event monitor on the falling edge: counts every strobe and remembers
   // the sample index of the most recent ones.
   always @(negedge clock) begin
      cyc++;
      if (clearOut === 1'b0) begin
         nClear++;
         lastClear = cyc;
      end
      if (load0Out === 1'b0) nLoad0++;
      if (load1Out === 1'b0) begin
         nLoad1++;
         prevLoad1 = lastLoad1;
         lastLoad1 = cyc;
      end
      if (shiftOut === 2'b01) nLeft++;
      if (shiftOut === 2'b10) begin
         nRight++;
         lastRight = cyc;
      end
      if (landedOut === 1'b1) nLanded++;
   end

   // Hard time limit so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // which: 0 start, 1 up, 2 down, 3 left, 4 right
   task automatic setButton(input int w, input logic v);
      case (w)
         0: startBtn = v;
         1: upBtn    = v;
         2: downBtn  = v;
         3: leftBtn  = v;
         default: rightBtn = v;
      endcase
   endtask

   task automatic applyStimulus(input int w, input int cycles);
      setButton(w, 1'b0);
      tick(cycles);
      setButton(w, 1'b1);
   endtask

   task automatic waitLoad1(input int target, input int limit);
      for (int k = 0; k < limit && nLoad1 < target; k++) tick(1);
   endtask

   task automatic waitLanded(input int target, input int limit);
      for (int k = 0; k < limit && nLanded < target; k++) tick(1);
   endtask

   initial begin
      resetLow = 1'b0;
      startBtn = 1'b1; upBtn = 1'b1; downBtn = 1'b1; leftBtn = 1'b1; rightBtn = 1'b1;
      bottomIn = 1'b1; topIn = 1'b1;
      tick(3);

      checkOutput("rst_clear", clearOut, 1);
      checkOutput("rst_load0", load0Out, 1);
      checkOutput("rst_load1", load1Out, 1);
      checkOutput("rst_shift", shiftOut, 3);
      checkOutput("rst_landed", landedOut, 0);
      checkOutput("rst_gameover", gameoverOut, 0);
      checkOutput("rst_lives", livesOut, LIVES);
      checkOutput("rst_level", levelOut, 0);

      resetLow = 1'b1;
      tick(2);

      // Start held for three cycles gives one clear pulse only.
      c0 = nClear;
      applyStimulus(0, 3);
      tick(4);
      checkOutput("start_clear_once", nClear - c0, 1);
      checkOutput("start_no_cmd", nLoad0 + nLoad1 + nLeft + nRight, 0);
      checkOutput("start_lives", livesOut, LIVES);
      checkOutput("start_level", levelOut, 0);

      // First gravity pulse lands 18 samples after the clear pulse
      // (P-1 counting cycles after RUN starts, plus two cycles of latency).
      base = lastClear + BASE + 2;

      // Random single presses; each must yield exactly one strobe of its kind.
      for (int i = 0; i < 8; i++) begin
         kind  = $urandom_range(0, 2);
         which = (kind == 0) ? 1 : ((kind == 1) ? 3 : 4);
         hold  = $urandom_range(3, 10);
         gap   = $urandom_range(2, 5);
         u0 = nLoad0; l0 = nLeft; r0 = nRight;
         applyStimulus(which, hold);
         tick(gap);
         obs  = (nLoad0 - u0) * 100 + (nLeft - l0) * 10 + (nRight - r0);
         expv = (kind == 0) ? 100 : ((kind == 1) ? 10 : 1);
         checkOutput($sformatf("press%0d_k%0d_h%0d", i, kind, hold), obs, expv);
      end

      // Gravity keeps its period through presses; stop mid-period and count.
      tick(20);
      for (int k = 0; k < BASE && ((cyc - base) % BASE) != BASE / 2; k++) tick(1);
      checkOutput("gravity_count_lvl0", nLoad1, (cyc - base) / BASE + 1);

      t = nLoad1;
      waitLoad1(t + 2, 3 * BASE);
      checkOutput("gravity_seen_lvl0", nLoad1, t + 2);
      checkOutput("spacing_lvl0", lastLoad1 - prevLoad1, BASE);

      // Right pressed during the expiry cycle: gravity first, right after.
      markL = lastLoad1;
      tick(13);
      applyStimulus(4, 6);
      tick(3);
      checkOutput("coinc_load1_count", nLoad1, t + 3);
      checkOutput("coinc_load1_time", lastLoad1, markL + BASE);
      checkOutput("coinc_right_time", lastRight, markL + BASE + 2);

      // Down on the bottom row is ignored.
      bottomIn = 1'b0;
      t   = nLoad1;
      ld0 = nLanded;
      applyStimulus(2, 4);
      tick(1);
      checkOutput("down_blocked_load1", nLoad1, t);
      checkOutput("down_blocked_landed", nLanded, ld0);

      // Four landings without overflow.
      c0 = nClear;
      landTotal = 0;
      for (int i = 1; i <= 4; i++) begin
         waitLanded(ld0 + i, 3 * BASE + 10);
         tick(3);
         landTotal++;
         modelLevel = (landTotal / LPL > MAXL) ? MAXL : landTotal / LPL;
         checkOutput($sformatf("land%0d_count", i), nLanded - ld0, landTotal);
         checkOutput($sformatf("land%0d_level", i), levelOut, modelLevel);
         checkOutput($sformatf("land%0d_clear", i), nClear - c0, landTotal);
      end

      // Faster gravity at the new level.
      bottomIn = 1'b1;
      t = nLoad1;
      waitLoad1(t + 2, 4 * BASE);
      checkOutput("gravity_seen_lvl2", nLoad1, t + 2);
      checkOutput("spacing_lvl2", lastLoad1 - prevLoad1, BASE - modelLevel * STEP);

      // Overflowing landings consume lives until the game is over.
      bottomIn = 1'b0;
      topIn    = 1'b0;
      ld0 = nLanded;
      waitLanded(ld0 + 1, 3 * BASE);
      tick(3);
      checkOutput("life1_lives", livesOut, LIVES - 1);
      checkOutput("life1_gameover", gameoverOut, 0);
      waitLanded(ld0 + 2, 3 * BASE);
      tick(2);
      checkOutput("life0_lives", livesOut, 0);
      checkOutput("life0_gameover", gameoverOut, 1);
      s0 = nClear + nLoad0 + nLoad1 + nLeft + nRight + nLanded;
      tick(12);
      checkOutput("gameover_quiet", nClear + nLoad0 + nLoad1 + nLeft + nRight + nLanded, s0);

      // Restart from game over.
      topIn    = 1'b1;
      bottomIn = 1'b1;
      c0 = nClear;
      applyStimulus(0, 2);
      tick(3);
      checkOutput("restart_clear", nClear - c0, 1);
      checkOutput("restart_lives", livesOut, LIVES);
      checkOutput("restart_level", levelOut, 0);
      checkOutput("restart_gameover", gameoverOut, 0);

      // Reset during an ISSUE cycle kills the strobe and returns to IDLE.
      leftBtn = 1'b0;
      for (int k = 0; k < 40 && shiftOut !== 2'b01; k++) tick(1);
      checkOutput("issue_left_seen", shiftOut, 1);
      resetLow = 1'b0;
      leftBtn  = 1'b1;
      tick(1);
      checkOutput("midrst_shift", shiftOut, 3);
      checkOutput("midrst_load1", load1Out, 1);
      checkOutput("midrst_clear", clearOut, 1);
      resetLow = 1'b1;
      c0 = nClear;
      t  = nLoad1;
      tick(BASE + 4);
      checkOutput("idle_no_clear", nClear, c0);
      checkOutput("idle_no_gravity", nLoad1, t);
      applyStimulus(0, 2);
      tick(2);
      checkOutput("idle_start_clear", nClear - c0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
